// File: rtl/scope_capture.sv
// scope_capture: small logic-analyser core driven by single-byte UART commands.
// Samples CHANNELS synchronized pins into a DEPTH-entry buffer (forced or triggered)
// and dumps the buffer over the UART transmit strobe interface with a 0xA5 header.
// Optional build macro: SCOPE_PRETRIGGER_EN -- keeps a circular pre-trigger history
// while armed and captures DEPTH/2 samples from the trigger onward.
module scope_capture #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 256,
    parameter int DIV      = 1,
    parameter int TRIG_CH  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] input_pins,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    input  logic                tx_busy,
    output logic                armed,
    output logic                done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = ADDR_W + 1;

    localparam logic [7:0] CMD_ARM   = 8'h61;
    localparam logic [7:0] CMD_FORCE = 8'h66;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_RESET = 8'h72;
    localparam logic [7:0] HEADER    = 8'hA5;

    localparam logic [15:0]       DIV_LAST  = 16'(DIV - 1);
    localparam logic [IDX_W-1:0]  DUMP_LAST = IDX_W'(DEPTH);
    // Samples still to be written after the first capture write (forced capture fills the buffer)
    localparam logic [ADDR_W-1:0] REM_FORCE = ADDR_W'(DEPTH - 1);
`ifdef SCOPE_PRETRIGGER_EN
    localparam logic [ADDR_W-1:0] REM_TRIG  = ADDR_W'(DEPTH / 2 - 2);
`else
    localparam logic [ADDR_W-1:0] REM_TRIG  = ADDR_W'(DEPTH - 2);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DUMP
    } state_t;

    state_t state;
    state_t state_next;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [15:0]         div_cnt;
    logic                tick;
    logic                prev_trig;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   remaining;
    logic [IDX_W-1:0]    dump_idx;
    logic [CHANNELS-1:0] mem [DEPTH];

    logic                cmd_arm;
    logic                cmd_force;
    logic                cmd_dump;
    logic                cmd_reset;
    logic                trig_hit;
    logic                cap_last;
    logic                wr_en;
    logic                send;
    logic                send_last;
    logic                entering_run;
    logic [7:0]          send_byte;
    logic [ADDR_W-1:0]   dump_start;

    assign cmd_arm   = new_rx_data && (rx_data == CMD_ARM);
    assign cmd_force = new_rx_data && (rx_data == CMD_FORCE);
    assign cmd_dump  = new_rx_data && (rx_data == CMD_DUMP);
    assign cmd_reset = new_rx_data && (rx_data == CMD_RESET);

    assign tick      = (div_cnt == DIV_LAST);
    assign trig_hit  = tick && !prev_trig && sync2[TRIG_CH];
    assign cap_last  = tick && (remaining == '0);
    // A byte is never offered in the cycle its predecessor is strobed, so the UART sees busy first
    assign send      = (state == S_DUMP) && !tx_busy && !new_tx_data && !cmd_reset;
    assign send_last = send && (dump_idx == DUMP_LAST);
    assign entering_run = (state_next != state) &&
                          ((state_next == S_ARMED) || (state_next == S_CAPTURE));

`ifdef SCOPE_PRETRIGGER_EN
    assign dump_start = wr_addr;
`else
    assign dump_start = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; "r" wins over everything else in every state
    always_comb begin
        state_next = state;
        if (cmd_reset) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_arm) begin
                        state_next = S_ARMED;
                    end else if (cmd_force) begin
                        state_next = S_CAPTURE;
                    end else if (cmd_dump) begin
                        state_next = S_DUMP;
                    end
                end
                S_ARMED: begin
                    if (trig_hit) begin
                        state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_last) begin
                        state_next = S_IDLE;
                    end
                end
                S_DUMP: begin
                    if (send_last) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs: armed flag, buffer write enable and the byte to transmit
    always_comb begin
        armed     = (state == S_ARMED);
        wr_en     = 1'b0;
        send_byte = HEADER;
        case (state)
`ifdef SCOPE_PRETRIGGER_EN
            S_ARMED:   wr_en = tick;
`else
            S_ARMED:   wr_en = trig_hit;
`endif
            S_CAPTURE: wr_en = tick;
            default:   wr_en = 1'b0;
        endcase
        if (dump_idx != '0) begin
            send_byte = 8'h00;
            send_byte[CHANNELS-1:0] = mem[rd_addr];
        end
    end

    // Two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= input_pins;
            sync2 <= sync1;
        end
    end

    // Free-running sample divider, realigned when arming or starting a capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (entering_run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Trigger channel value at the previous tick, for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_trig <= 1'b0;
        end else if (tick) begin
            prev_trig <= sync2[TRIG_CH];
        end
    end

    // Write pointer and remaining-sample count for the current capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr   <= '0;
            remaining <= '0;
        end else if ((state == S_IDLE) && (state_next == S_ARMED)) begin
            wr_addr <= '0;
        end else if ((state == S_IDLE) && (state_next == S_CAPTURE)) begin
            wr_addr   <= '0;
            remaining <= REM_FORCE;
        end else if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            if (state == S_ARMED) begin
                if (trig_hit) begin
                    remaining <= REM_TRIG;
                end
            end else if (remaining != '0) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Sample buffer; deliberately not reset so a dump after reset shows the old contents
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_addr] <= sync2;
        end
    end

    // Completion flag, cleared by the next arm/force command or by "r"
    always_ff @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
        end else if (cmd_reset) begin
            done <= 1'b0;
        end else if ((state == S_IDLE) && (cmd_arm || cmd_force)) begin
            done <= 1'b0;
        end else if ((state == S_CAPTURE) && cap_last) begin
            done <= 1'b1;
        end
    end

    // Dump sequencer: header first, then DEPTH buffer entries, one strobe per byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            dump_idx    <= '0;
            rd_addr     <= '0;
            new_tx_data <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            new_tx_data <= send;
            if (state != S_DUMP) begin
                dump_idx <= '0;
                rd_addr  <= dump_start;
            end
            if (send) begin
                tx_data  <= send_byte;
                dump_idx <= dump_idx + 1'b1;
                if (dump_idx != '0) begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed self-checking bench for scope_capture
// (CHANNELS=4, DEPTH=16, DIV=1, TRIG_CH=0). Honours SCOPE_PRETRIGGER_EN when defined.
module tb_scope_capture;

    logic       clk;
    logic       rst;
    logic [3:0] input_pins;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       armed;
    logic       done;

    int         vectors;
    int         miscompares;
    logic [7:0] got [32];
    int         n_got;
    int         busy_viol;
    logic       saw_done;

    scope_capture #(
        .CHANNELS(4),
        .DEPTH(16),
        .DIV(1),
        .TRIG_CH(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .input_pins(input_pins),
        .rx_data(rx_data),
        .new_rx_data(new_rx_data),
        .tx_data(tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy(tx_busy),
        .armed(armed),
        .done(done)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Send one UART command byte as a single-cycle strobe
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    // Collect dump strobes; optionally hold tx_busy after each one, optionally send "r"
    task automatic runDump(input int busy_hold, input int stop_after);
        int  quiet;
        int  busy_left;
        int  guard;
        bit  r_pending;
        n_got     = 0;
        busy_viol = 0;
        saw_done  = 1'b0;
        quiet     = 0;
        busy_left = 0;
        guard     = 0;
        r_pending = 1'b0;
        while (quiet < 80 && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (r_pending) begin
                new_rx_data = 1'b0;
                rx_data     = 8'h00;
                r_pending   = 1'b0;
            end
            if (done) saw_done = 1'b1;
            if (new_tx_data) begin
                if (tx_busy) busy_viol++;
                if (n_got < 32) got[n_got] = tx_data;
                n_got++;
                quiet = 0;
                if (busy_hold > 0) begin
                    tx_busy   = 1'b1;
                    busy_left = busy_hold;
                end
                if (n_got == stop_after) begin
                    rx_data     = 8'h72;
                    new_rx_data = 1'b1;
                    r_pending   = 1'b1;
                end
            end else begin
                quiet++;
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) tx_busy = 1'b0;
                end
            end
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_pre [17];
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        input_pins  = 4'h0;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        tx_busy     = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_armed", 32'(armed), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_new_tx", 32'(new_tx_data), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h00);

        // Dump before any capture
        applyStimulus(8'h64);
        runDump(0, 0);
        checkOutput("dump0_count", 32'(n_got), 32'd17);
        checkOutput("dump0_header", 32'(got[0]), 32'hA5);
        checkOutput("dump0_done_low", 32'(saw_done), 32'd0);

`ifdef SCOPE_PRETRIGGER_EN
        // Pretrigger: counting pattern on bits 3:1, then trigger value 0x1, then odd values
        applyStimulus(8'h61);
        checkOutput("arm_armed", 32'(armed), 32'd1);
        for (int i = 0; i < 20; i++) begin
            input_pins = 4'(((i % 8) << 1));
            @(posedge clk);
            #1;
        end
        input_pins = 4'h1;
        @(posedge clk);
        #1;
        for (int j = 1; j < 8; j++) begin
            input_pins = 4'((j << 1) | 1);
            @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_done", 32'(done), 32'd1);
        checkOutput("pre_armed_low", 32'(armed), 32'd0);
        exp_pre = '{8'hA5, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h00, 8'h02, 8'h04, 8'h06,
                    8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F};
        applyStimulus(8'h64);
        runDump(0, 0);
        checkOutput("pre_count", 32'(n_got), 32'd17);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("pre_byte%0d", k), 32'(got[k]), 32'(exp_pre[k]));
        end
`else
        // Triggered capture on a ramp; trigger fires on the first 0x1
        applyStimulus(8'h61);
        checkOutput("arm_armed", 32'(armed), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int i = 1; i <= 40; i++) begin
            input_pins = 4'(i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("ramp_done", 32'(done), 32'd1);
        checkOutput("ramp_armed_low", 32'(armed), 32'd0);
        for (int k = 0; k < 17; k++) exp_pre[k] = (k == 0) ? 8'hA5 : 8'(k & 15);
        applyStimulus(8'h64);
        runDump(0, 0);
        checkOutput("ramp_count", 32'(n_got), 32'd17);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("ramp_byte%0d", k), 32'(got[k]), 32'(exp_pre[k]));
        end
`endif

        // Forced capture with constant pins
        input_pins = 4'hA;
        repeat (5) @(posedge clk);
        applyStimulus(8'h66);
        checkOutput("force_done_cleared", 32'(done), 32'd0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("force_done", 32'(done), 32'd1);
        applyStimulus(8'h64);
        runDump(0, 0);
        checkOutput("force_count", 32'(n_got), 32'd17);
        checkOutput("force_header", 32'(got[0]), 32'hA5);
        for (int k = 1; k < 17; k++) begin
            checkOutput($sformatf("force_byte%0d", k), 32'(got[k]), 32'h0A);
        end

        // Slow receiver: tx_busy held 50 cycles after every strobe
        applyStimulus(8'h64);
        runDump(50, 0);
        checkOutput("busy_count", 32'(n_got), 32'd17);
        checkOutput("busy_violations", 32'(busy_viol), 32'd0);
        checkOutput("busy_header", 32'(got[0]), 32'hA5);
        checkOutput("busy_last", 32'(got[16]), 32'h0A);

        // Abort a dump with "r" after five strobes, then dump again
        applyStimulus(8'h64);
        runDump(0, 5);
        checkOutput("abort_count", 32'(n_got), 32'd5);
        checkOutput("abort_armed", 32'(armed), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        applyStimulus(8'h64);
        runDump(0, 0);
        checkOutput("redump_count", 32'(n_got), 32'd17);
        checkOutput("redump_header", 32'(got[0]), 32'hA5);
        checkOutput("redump_byte1", 32'(got[1]), 32'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
